eim_frame_timing_gen: RTL and testbench

//  Parametrised raster timing generator for the EIM readout data path. Produces VSYNC/HSYNC

---
 rtl/eim_frame_timing_gen_if.sv | 22 ++
 rtl/eim_frame_timing_gen.sv | 187 ++++++++++++++++++
 tb/tb_eim_frame_timing_gen.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/eim_frame_timing_gen_if.sv
// AXI-Stream beat bus with raster position sideband.
// Carries beats from the frame timing generator to the read data mux / AXIS packer.
interface eim_frame_timing_gen_if #(
  parameter int CNT_W = 16
);
  logic             axis_tvalid;
  logic             axis_tready;
  logic             axis_tuser;
  logic             axis_tlast;
  logic [CNT_W-1:0] h_count;
  logic [CNT_W-1:0] v_count;

  modport master (
    output axis_tvalid, axis_tuser, axis_tlast, h_count, v_count,
    input  axis_tready
  );

  modport slave (
    input  axis_tvalid, axis_tuser, axis_tlast, h_count, v_count,
    output axis_tready
  );
endinterface

// File: rtl/eim_frame_timing_gen.sv
// Raster timing generator for the EIM readout path: VSYNC/HSYNC framing, h/v counters and
// AXI-Stream sideband with full tready backpressure, single-shot or continuous frames.
module eim_frame_timing_gen #(
  parameter int CNT_W      = 16,
  parameter int HSYNC_W    = 6,
  parameter int VSYNC_W    = 16,
  parameter int FSTART_DLY = 12
) (
  input  logic                   eim_clk,
  input  logic                   eim_rst,
  input  logic                   soft_rst_n,
  input  logic [CNT_W-1:0]       cfg_h_active,
  input  logic [CNT_W-1:0]       cfg_v_active,
  input  logic [CNT_W-1:0]       cfg_h_blank,
  input  logic [CNT_W-1:0]       cfg_v_blank,
  input  logic                   cfg_continuous,
  input  logic                   start,
  eim_frame_timing_gen_if.master axis,
  output logic                   hsync,
  output logic                   vsync,
  output logic                   frame_start,
  output logic                   frame_done,
  output logic                   busy,
  output logic                   cfg_err
);

  typedef enum logic [2:0] {S_IDLE, S_VS, S_ACT, S_HBLK, S_FEND} state_t;

  localparam logic [CNT_W-1:0] VS_LAST = CNT_W'(VSYNC_W - 1);
  localparam logic [CNT_W-1:0] HS_LAST = CNT_W'(HSYNC_W - 1);

  state_t                state;
  logic [CNT_W-1:0]      h_cnt;
  logic [CNT_W-1:0]      v_cnt;
  logic [CNT_W-1:0]      tmr;
  logic                  tvalid;
  logic [CNT_W-1:0]      h_last;
  logic [CNT_W-1:0]      v_last;
  logic [CNT_W-1:0]      hb_last;
  logic [CNT_W-1:0]      vb_last;
  logic [FSTART_DLY-1:0] sof_dly;

  logic cfg_ok;
  logic accept;
  logic eol;
  logic sof;

  assign cfg_ok = (cfg_h_active >= CNT_W'(2)) && (cfg_v_active != '0);
  assign accept = (state == S_IDLE) && start && cfg_ok;
  assign eol    = (h_cnt == h_last);
  assign sof    = tvalid && (h_cnt == '0) && (v_cnt == '0);

  assign axis.axis_tvalid = tvalid;
  assign axis.axis_tuser  = sof;
  assign axis.axis_tlast  = tvalid && eol;
  assign axis.h_count     = h_cnt;
  assign axis.v_count     = v_cnt;
  assign frame_start      = sof_dly[FSTART_DLY-1];

  // NOTE: shadow geometry is only read after a start has loaded it, so it needs no reset.
  // Last-index values are precomputed here so the frame loop compares without subtracting.
  always_ff @(posedge eim_clk) begin
    if (accept) begin
      h_last  <= cfg_h_active - 1'b1;
      v_last  <= cfg_v_active - 1'b1;
      hb_last <= (cfg_h_blank == '0) ? '0 : cfg_h_blank - 1'b1;
      vb_last <= (cfg_v_blank == '0) ? '0 : cfg_v_blank - 1'b1;
    end
  end

  always_ff @(posedge eim_clk or posedge eim_rst) begin
    if (eim_rst) begin
      state      <= S_IDLE;
      h_cnt      <= '0;
      v_cnt      <= '0;
      tmr        <= '0;
      tvalid     <= 1'b0;
      hsync      <= 1'b0;
      vsync      <= 1'b0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
      cfg_err    <= 1'b0;
    end else if (!soft_rst_n) begin
      state      <= S_IDLE;
      h_cnt      <= '0;
      v_cnt      <= '0;
      tmr        <= '0;
      tvalid     <= 1'b0;
      hsync      <= 1'b0;
      vsync      <= 1'b0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      // NOTE: non-blocking throughout, so every branch below reads the pre-edge values.
      frame_done <= 1'b0;
      cfg_err    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (cfg_ok) begin
              state <= S_VS;
              vsync <= 1'b1;
              busy  <= 1'b1;
              tmr   <= '0;
            end else begin
              cfg_err <= 1'b1;
            end
          end
        end
        S_VS: begin
          if (tmr == VS_LAST) begin
            state  <= S_ACT;
            vsync  <= 1'b0;
            tvalid <= 1'b1;
            h_cnt  <= '0;
            v_cnt  <= '0;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        S_ACT: begin
          // tvalid stays high until the beat is taken; stalls freeze h/v.
          if (axis.axis_tready) begin
            if (!eol) begin
              h_cnt <= h_cnt + 1'b1;
            end else begin
              h_cnt  <= '0;
              tvalid <= 1'b0;
              tmr    <= '0;
              if (v_cnt == v_last) begin
                state      <= S_FEND;
                frame_done <= 1'b1;
                v_cnt      <= '0;
              end else begin
                state <= S_HBLK;
                hsync <= 1'b1;
                v_cnt <= v_cnt + 1'b1;
              end
            end
          end
        end
        S_HBLK: begin
          if (tmr == hb_last) begin
            state  <= S_ACT;
            hsync  <= 1'b0;
            tvalid <= 1'b1;
          end else begin
            tmr   <= tmr + 1'b1;
            hsync <= (tmr < HS_LAST);
          end
        end
        S_FEND: begin
          // cfg_continuous is sampled live so clearing it ends the run after this frame.
          if (tmr == vb_last) begin
            tmr <= '0;
            if (cfg_continuous) begin
              state <= S_VS;
              vsync <= 1'b1;
            end else begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Pipelined SOF handshake; a pulse in flight survives the start of the next frame.
  always_ff @(posedge eim_clk or posedge eim_rst) begin
    if (eim_rst) begin
      sof_dly <= '0;
    end else if (!soft_rst_n) begin
      sof_dly <= '0;
    end else begin
      sof_dly <= FSTART_DLY'({sof_dly, sof && axis.axis_tready});
    end
  end

endmodule

// File: tb/tb_eim_frame_timing_gen.sv
// Scoreboard bench for eim_frame_timing_gen: a raster model queues expected beats and
// frame_start times; a negedge monitor pops and compares whatever the DUT presents.
module tb_eim_frame_timing_gen;
  localparam int CNT_W      = 16;
  localparam int HSYNC_W    = 6;
  localparam int VSYNC_W    = 16;
  localparam int FSTART_DLY = 12;

  typedef struct {
    int h;
    int v;
    bit tuser;
    bit tlast;
  } beat_t;

  logic             eim_clk = 1'b0;
  logic             eim_rst = 1'b0;
  logic             soft_rst_n = 1'b1;
  logic [CNT_W-1:0] cfg_h_active = 16'd4;
  logic [CNT_W-1:0] cfg_v_active = 16'd2;
  logic [CNT_W-1:0] cfg_h_blank = 16'd3;
  logic [CNT_W-1:0] cfg_v_blank = 16'd2;
  logic             cfg_continuous = 1'b0;
  logic             start = 1'b0;
  logic             hsync, vsync, frame_start, frame_done, busy, cfg_err;

  eim_frame_timing_gen_if #(.CNT_W(CNT_W)) axis_if ();

  eim_frame_timing_gen #(
    .CNT_W(CNT_W), .HSYNC_W(HSYNC_W), .VSYNC_W(VSYNC_W), .FSTART_DLY(FSTART_DLY)
  ) dut (
    .eim_clk       (eim_clk),
    .eim_rst       (eim_rst),
    .soft_rst_n    (soft_rst_n),
    .cfg_h_active  (cfg_h_active),
    .cfg_v_active  (cfg_v_active),
    .cfg_h_blank   (cfg_h_blank),
    .cfg_v_blank   (cfg_v_blank),
    .cfg_continuous(cfg_continuous),
    .start         (start),
    .axis          (axis_if.master),
    .hsync         (hsync),
    .vsync         (vsync),
    .frame_start   (frame_start),
    .frame_done    (frame_done),
    .busy          (busy),
    .cfg_err       (cfg_err)
  );

  always #5 eim_clk = ~eim_clk;

  longint cyc = 0;
  always @(posedge eim_clk) cyc <= cyc + 1;

  int     total = 0;
  int     bad = 0;
  beat_t  exp_q[$];
  longint fs_q[$];
  longint gap_q[$];
  longint last_beat_cyc = 0;
  bit     have_last = 1'b0;
  int     n_hsync = 0;
  int     n_fdone = 0;
  int     n_cfgerr = 0;
  int     n_sof = 0;
  int     rdy_mode = 0;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  task automatic tick();
    @(posedge eim_clk);
    #1;
  endtask

  // Reference raster: every line is h beats, beat 0 of line 0 is SOF, beat h-1 is EOL.
  task automatic push_frame(input int h, input int v);
    for (int vv = 0; vv < v; vv++)
      for (int hh = 0; hh < h; hh++)
        exp_q.push_back('{h: hh, v: vv, tuser: (hh == 0 && vv == 0), tlast: (hh == h - 1)});
  endtask

  task automatic set_cfg(input int h, input int v, input int hb, input int vb);
    cfg_h_active = CNT_W'(h);
    cfg_v_active = CNT_W'(v);
    cfg_h_blank  = CNT_W'(hb);
    cfg_v_blank  = CNT_W'(vb);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      tick();
      if (!busy) break;
    end
    check("idle_timeout_busy", busy, 0);
  endtask

  // One single-shot frame; poke re-triggers start with scrambled cfg while the frame runs.
  task automatic run_frame(input int h, input int v, input int hb, input int vb,
                           input int mode, input bit poke);
    int hs0, fd0, ce0;
    set_cfg(h, v, hb, vb);
    cfg_continuous = 1'b0;
    rdy_mode = mode;
    hs0 = n_hsync;
    fd0 = n_fdone;
    ce0 = n_cfgerr;
    push_frame(h, v);
    pulse_start();
    if (poke) begin
      repeat (16) tick();
      set_cfg($urandom_range(0, 9), $urandom_range(0, 4), $urandom_range(0, 7), $urandom_range(0, 7));
      start = 1'b1;
      tick();
      start = 1'b0;
    end
    wait_idle(4000);
    check("beats_left", exp_q.size(), 0);
    check("frame_done_cnt", n_fdone - fd0, 1);
    check("hsync_cycles", n_hsync - hs0, (v - 1) * imin(HSYNC_W, imax(hb, 1)));
    check("cfg_err_cnt", n_cfgerr - ce0, 0);
    repeat (FSTART_DLY + 2) tick();
    check("frame_start_left", fs_q.size(), 0);
  endtask

  initial begin
    axis_if.axis_tready = 1'b0;
    forever begin
      @(posedge eim_clk);
      #1;
      case (rdy_mode)
        0:       axis_if.axis_tready = 1'b1;
        1:       axis_if.axis_tready = ~axis_if.axis_tready;
        default: axis_if.axis_tready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Monitor: scoreboard pops, stall stability, frame_start latency, pulse counters.
  initial begin
    beat_t b;
    beat_t snap;
    bit    stalled;
    stalled = 1'b0;
    forever begin
      @(negedge eim_clk);
      if (stalled) begin
        check("stall_tvalid", axis_if.axis_tvalid, 1);
        check("stall_h", axis_if.h_count, snap.h);
        check("stall_v", axis_if.v_count, snap.v);
        check("stall_tuser", axis_if.axis_tuser, snap.tuser);
        check("stall_tlast", axis_if.axis_tlast, snap.tlast);
      end
      stalled = axis_if.axis_tvalid && !axis_if.axis_tready;
      if (stalled) begin
        snap.h     = int'(axis_if.h_count);
        snap.v     = int'(axis_if.v_count);
        snap.tuser = axis_if.axis_tuser;
        snap.tlast = axis_if.axis_tlast;
      end
      if (axis_if.axis_tvalid && axis_if.axis_tready) begin
        check("beat_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          b = exp_q.pop_front();
          check("beat_h", axis_if.h_count, b.h);
          check("beat_v", axis_if.v_count, b.v);
          check("beat_tuser", axis_if.axis_tuser, b.tuser);
          check("beat_tlast", axis_if.axis_tlast, b.tlast);
        end
        if (axis_if.axis_tuser) begin
          n_sof++;
          fs_q.push_back(cyc + FSTART_DLY);
          if (have_last) gap_q.push_back(cyc - last_beat_cyc);
        end
        last_beat_cyc = cyc;
        have_last = 1'b1;
      end
      if (frame_start) begin
        check("frame_start_expected", fs_q.size() != 0, 1);
        if (fs_q.size() != 0) check("frame_start_cycle", cyc, fs_q.pop_front());
      end
      n_hsync  += int'(hsync);
      n_fdone  += int'(frame_done);
      n_cfgerr += int'(cfg_err);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int fd0, ce0, sof0;
    bit hit;

    // Reset state
    #1 eim_rst = 1'b1;
    repeat (3) tick();
    check("rst_tvalid", axis_if.axis_tvalid, 0);
    check("rst_busy", busy, 0);
    eim_rst = 1'b0;
    tick();
    check("rst_h", axis_if.h_count, 0);
    check("rst_v", axis_if.v_count, 0);
    check("rst_sync", {hsync, vsync}, 0);
    check("rst_pulses", {frame_start, frame_done, cfg_err}, 0);
    check("rst_sideband", {axis_if.axis_tuser, axis_if.axis_tlast}, 0);

    // 4x2 frame, tready always high, then with tready toggling each cycle
    run_frame(4, 2, 3, 2, 0, 1'b0);
    run_frame(4, 2, 3, 2, 1, 1'b0);

    // Invalid geometry: h_active=1, then v_active=0
    rdy_mode = 0;
    set_cfg(1, 2, 3, 2);
    pulse_start();
    check("cfg_err_h_pulse", cfg_err, 1);
    check("cfg_err_h_busy", busy, 0);
    tick();
    check("cfg_err_h_clear", cfg_err, 0);
    check("cfg_err_h_tvalid", axis_if.axis_tvalid, 0);
    set_cfg(4, 0, 3, 2);
    ce0 = n_cfgerr;
    pulse_start();
    repeat (3) tick();
    check("cfg_err_v_cnt", n_cfgerr - ce0, 1);
    check("cfg_err_v_busy", busy, 0);

    // Continuous 2x1 frames, separated by vblank + VSYNC_W; clear continuous in frame 3
    set_cfg(2, 1, 1, 3);
    cfg_continuous = 1'b1;
    rdy_mode = 0;
    gap_q.delete();
    have_last = 1'b0;
    fd0 = n_fdone;
    sof0 = n_sof;
    repeat (3) push_frame(2, 1);
    pulse_start();
    hit = 1'b0;
    for (int i = 0; i < 500; i++) begin
      tick();
      if (n_sof - sof0 == 3) begin
        hit = 1'b1;
        break;
      end
    end
    check("cont_sof_count", n_sof - sof0, 3);
    cfg_continuous = 1'b0;
    wait_idle(500);
    check("cont_beats_left", exp_q.size(), 0);
    check("cont_frame_done", n_fdone - fd0, 3);
    check("cont_gap_count", gap_q.size(), 2);
    while (gap_q.size() != 0) check("cont_gap", gap_q.pop_front(), 3 + VSYNC_W + 1);
    repeat (FSTART_DLY + 2) tick();
    check("cont_frame_start_left", fs_q.size(), 0);

    // Second start while busy (with scrambled cfg) is ignored
    run_frame(4, 2, 3, 2, 0, 1'b1);

    // Soft reset during line 1 aborts the frame and cancels the pending frame_start
    set_cfg(4, 2, 3, 2);
    rdy_mode = 0;
    fd0 = n_fdone;
    push_frame(4, 2);
    pulse_start();
    hit = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (axis_if.axis_tvalid && axis_if.v_count == 1) begin
        hit = 1'b1;
        break;
      end
    end
    check("srst_reached_line1", hit, 1);
    soft_rst_n = 1'b0;
    tick();
    exp_q.delete();
    fs_q.delete();
    check("srst_tvalid", axis_if.axis_tvalid, 0);
    check("srst_busy", busy, 0);
    check("srst_counts", {axis_if.h_count, axis_if.v_count}, 0);
    check("srst_outputs", {hsync, vsync, frame_done, frame_start, cfg_err}, 0);
    soft_rst_n = 1'b1;
    repeat (FSTART_DLY + 4) tick();
    check("srst_no_frame_done", n_fdone - fd0, 0);
    run_frame(4, 2, 3, 2, 0, 1'b0);

    // Randomized geometry and backpressure
    for (int i = 0; i < 8; i++)
      run_frame($urandom_range(2, 6), $urandom_range(1, 3), $urandom_range(0, 8),
                $urandom_range(0, 3), 2, i[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
